// File: rtl/alu_issue_dec.sv
// RV32I decode/issue stage: builds the ALU operand/control bundle from an
// instruction and register reads, held in a one-entry handshaked register.
module alu_issue_dec #(
  parameter int DATA_LEN  = 32,
  parameter int SHAMT_LEN = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         inst,
  input  logic [DATA_LEN-1:0] pc,
  input  logic [DATA_LEN-1:0] rs1_data,
  input  logic [DATA_LEN-1:0] rs2_data,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] NUM_A,
  output logic [DATA_LEN-1:0] NUM_B,
  output logic                OP,
  output logic                LR,
  output logic                AL,
  output logic                is_or,
  output logic                is_and,
  output logic                is_xor,
  output logic                is_cmp,
  output logic                is_shift,
  output logic                is_sign,
  output logic [2:0]          br_type,
  output logic [DATA_LEN-1:0] st_data,
  output logic [4:0]          rd,
  output logic                wen,
  output logic                illegal
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  function automatic logic signed [DATA_LEN-1:0] imm_i(input logic [31:0] w);
    imm_i = DATA_LEN'($signed(w[31:20]));
  endfunction

  function automatic logic signed [DATA_LEN-1:0] imm_s(input logic [31:0] w);
    imm_s = DATA_LEN'($signed({w[31:25], w[11:7]}));
  endfunction

  function automatic logic signed [DATA_LEN-1:0] imm_u(input logic [31:0] w);
    imm_u = DATA_LEN'($signed({w[31:12], 12'b0}));
  endfunction

  function automatic logic signed [DATA_LEN-1:0] shamt_zx(input logic [31:0] w);
    shamt_zx = DATA_LEN'(w[20 +: SHAMT_LEN]);
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  logic signed [DATA_LEN-1:0] d_num_a, d_num_b, d_st_data;
  logic                       d_op, d_lr, d_al, d_or, d_and, d_xor, d_cmp, d_shift, d_sign;
  logic [2:0]                 d_br_type;
  logic [4:0]                 d_rd;
  logic                       d_wen, d_ill;

  always_comb begin
    d_num_a   = '0;
    d_num_b   = '0;
    d_st_data = '0;
    d_op      = 1'b0;
    d_lr      = 1'b0;
    d_al      = 1'b0;
    d_or      = 1'b0;
    d_and     = 1'b0;
    d_xor     = 1'b0;
    d_cmp     = 1'b0;
    d_shift   = 1'b0;
    d_sign    = 1'b0;
    d_br_type = 3'd0;
    d_rd      = 5'd0;
    d_wen     = 1'b0;
    d_ill     = 1'b0;

    case (opcode)
      OPC_OP_IMM, OPC_OP: begin
        d_num_a = rs1_data;
        d_rd    = inst[11:7];
        d_wen   = 1'b1;
        if (opcode == OPC_OP) d_num_b = rs2_data;
        else if (funct3 == 3'd1 || funct3 == 3'd5) d_num_b = shamt_zx(inst);
        else d_num_b = imm_i(inst);
        // Register forms check funct7 for every funct3; immediates only for shifts.
        case (funct3)
          3'd0: begin
            if (opcode == OPC_OP) begin
              if (funct7 == F7_ALT) d_op = 1'b1;
              else if (funct7 != F7_BASE) d_ill = 1'b1;
            end
          end
          3'd1: begin
            d_shift = 1'b1;
            d_lr    = 1'b1;
            if (funct7 != F7_BASE) d_ill = 1'b1;
          end
          3'd5: begin
            d_shift = 1'b1;
            if (funct7 == F7_ALT) d_al = 1'b1;
            else if (funct7 != F7_BASE) d_ill = 1'b1;
          end
          default: begin
            if (opcode == OPC_OP && funct7 != F7_BASE) d_ill = 1'b1;
            case (funct3)
              3'd2:    begin d_cmp = 1'b1; d_op = 1'b1; d_sign = 1'b1; end
              3'd3:    begin d_cmp = 1'b1; d_op = 1'b1; end
              3'd4:    d_xor = 1'b1;
              3'd6:    d_or  = 1'b1;
              default: d_and = 1'b1;
            endcase
          end
        endcase
      end
      OPC_LUI: begin
        d_num_b = imm_u(inst);
        d_rd    = inst[11:7];
        d_wen   = 1'b1;
      end
      OPC_AUIPC: begin
        d_num_a = pc;
        d_num_b = imm_u(inst);
        d_rd    = inst[11:7];
        d_wen   = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        d_num_a = pc;
        d_num_b = DATA_LEN'(4);
        d_rd    = inst[11:7];
        d_wen   = 1'b1;
        if (opcode == OPC_JALR && funct3 != 3'd0) d_ill = 1'b1;
      end
      OPC_BRANCH: begin
        d_num_a = rs1_data;
        d_num_b = rs2_data;
        d_op    = 1'b1;
        case (funct3)
          3'd0:    d_br_type = 3'd1;
          3'd1:    d_br_type = 3'd2;
          3'd4:    begin d_br_type = 3'd3; d_sign = 1'b1; end
          3'd5:    begin d_br_type = 3'd4; d_sign = 1'b1; end
          3'd6:    d_br_type = 3'd5;
          3'd7:    d_br_type = 3'd6;
          default: d_ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d_num_a = rs1_data;
        d_num_b = imm_i(inst);
        d_rd    = inst[11:7];
        d_wen   = 1'b1;
        if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) d_ill = 1'b1;
      end
      OPC_STORE: begin
        d_num_a   = rs1_data;
        d_num_b   = imm_s(inst);
        d_st_data = rs2_data;
        if (funct3 > 3'd2) d_ill = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase

    // An illegal instruction travels as an inert bundle carrying only the flag.
    if (d_ill) begin
      d_num_a   = '0;
      d_num_b   = '0;
      d_st_data = '0;
      d_op      = 1'b0;
      d_lr      = 1'b0;
      d_al      = 1'b0;
      d_or      = 1'b0;
      d_and     = 1'b0;
      d_xor     = 1'b0;
      d_cmp     = 1'b0;
      d_shift   = 1'b0;
      d_sign    = 1'b0;
      d_br_type = 3'd0;
      d_rd      = 5'd0;
      d_wen     = 1'b0;
    end
    if (d_rd == 5'd0) d_wen = 1'b0;
  end

  // Stage p0: handshaked bundle register toward execute
  logic [0:0]                 state_p0;
  logic signed [DATA_LEN-1:0] num_a_p0, num_b_p0, st_data_p0;
  logic                       op_p0, lr_p0, al_p0, or_p0, and_p0, xor_p0, cmp_p0, shift_p0, sign_p0;
  logic [2:0]                 br_type_p0;
  logic [4:0]                 rd_p0;
  logic                       wen_p0, ill_p0;
  logic                       load;

  assign in_ready = (state_p0 == ST_EMPTY) | out_ready;
  assign load     = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0   <= ST_EMPTY;
      num_a_p0   <= '0;
      num_b_p0   <= '0;
      st_data_p0 <= '0;
      op_p0      <= 1'b0;
      lr_p0      <= 1'b0;
      al_p0      <= 1'b0;
      or_p0      <= 1'b0;
      and_p0     <= 1'b0;
      xor_p0     <= 1'b0;
      cmp_p0     <= 1'b0;
      shift_p0   <= 1'b0;
      sign_p0    <= 1'b0;
      br_type_p0 <= 3'd0;
      rd_p0      <= 5'd0;
      wen_p0     <= 1'b0;
      ill_p0     <= 1'b0;
    end else if (flush) begin
      state_p0 <= ST_EMPTY;
    end else if (load) begin
      state_p0   <= ST_FULL;
      num_a_p0   <= d_num_a;
      num_b_p0   <= d_num_b;
      st_data_p0 <= d_st_data;
      op_p0      <= d_op;
      lr_p0      <= d_lr;
      al_p0      <= d_al;
      or_p0      <= d_or;
      and_p0     <= d_and;
      xor_p0     <= d_xor;
      cmp_p0     <= d_cmp;
      shift_p0   <= d_shift;
      sign_p0    <= d_sign;
      br_type_p0 <= d_br_type;
      rd_p0      <= d_rd;
      wen_p0     <= d_wen;
      ill_p0     <= d_ill;
    end else if (out_ready) begin
      state_p0 <= ST_EMPTY;
    end
  end

  assign out_valid = (state_p0 == ST_FULL);
  assign NUM_A     = num_a_p0;
  assign NUM_B     = num_b_p0;
  assign st_data   = st_data_p0;
  assign OP        = op_p0;
  assign LR        = lr_p0;
  assign AL        = al_p0;
  assign is_or     = or_p0;
  assign is_and    = and_p0;
  assign is_xor    = xor_p0;
  assign is_cmp    = cmp_p0;
  assign is_shift  = shift_p0;
  assign is_sign   = sign_p0;
  assign br_type   = br_type_p0;
  assign rd        = rd_p0;
  assign wen       = wen_p0;
  assign illegal   = ill_p0;

endmodule

// File: tb/tb_alu_issue_dec.sv
// Bench for alu_issue_dec: per-cycle stimulus records feed a monitor that
// tracks the expected handshake state and compares bundles with a reference decoder.
module tb_alu_issue_dec;

  typedef struct packed {
    logic [31:0] num_a;
    logic [31:0] num_b;
    logic [31:0] st;
    logic [4:0]  rd;
    logic [2:0]  br;
    logic        op, lr, al, f_or, f_and, f_xor, f_cmp, f_shift, sgn, wen, ill;
  } bundle_t;

  typedef struct {
    bit      rst, flush, in_valid, out_ready;
    bundle_t exp;
  } stim_t;

  localparam int FN_ADD = 0, FN_SUB = 1, FN_SLT = 2, FN_SLTU = 3, FN_AND = 4,
                 FN_OR = 5, FN_XOR = 6, FN_SLL = 7, FN_SRL = 8, FN_SRA = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] inst = '0, pc = '0, rs1_data = '0, rs2_data = '0;
  logic        flush = 1'b0, out_valid, out_ready = 1'b0;
  logic [31:0] NUM_A, NUM_B, st_data;
  logic        OP, LR, AL, is_or, is_and, is_xor, is_cmp, is_shift, is_sign, wen, illegal;
  logic [2:0]  br_type;
  logic [4:0]  rd;

  alu_issue_dec #(.DATA_LEN(32), .SHAMT_LEN(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .NUM_A(NUM_A), .NUM_B(NUM_B), .OP(OP), .LR(LR), .AL(AL),
    .is_or(is_or), .is_and(is_and), .is_xor(is_xor), .is_cmp(is_cmp), .is_shift(is_shift),
    .is_sign(is_sign), .br_type(br_type), .st_data(st_data), .rd(rd), .wen(wen),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  bundle_t dut_b;
  assign dut_b = {NUM_A, NUM_B, st_data, rd, br_type, OP, LR, AL, is_or, is_and, is_xor,
                  is_cmp, is_shift, is_sign, wen, illegal};

  int    checks = 0;
  int    errors = 0;
  stim_t stim_q[$];

  // Reference: classify the instruction into an ALU function, then derive the bundle.
  function automatic bundle_t ref_decode(input logic [31:0] i, input logic [31:0] pcv,
                                         input logic [31:0] a, input logic [31:0] b);
    bundle_t     r;
    logic [31:0] imm_i, imm_s, imm_u;
    int          f3, f7, fn, brk;
    bit          legal, writes;
    int          br_map[8] = '{1, 2, 0, 0, 3, 4, 5, 6};
    imm_i  = 32'($signed(i[31:20]));
    imm_s  = 32'($signed({i[31:25], i[11:7]}));
    imm_u  = {i[31:12], 12'h000};
    f3     = int'(i[14:12]);
    f7     = int'(i[31:25]);
    r      = '0;
    legal  = 1'b1;
    writes = 1'b0;
    fn     = FN_ADD;
    case (i[6:0])
      7'h13, 7'h33: begin
        writes  = 1'b1;
        r.num_a = a;
        if (i[5]) r.num_b = b;
        else if (f3 == 1 || f3 == 5) r.num_b = {27'd0, i[24:20]};
        else r.num_b = imm_i;
        case (f3)
          0: fn = (i[5] && f7 == 32) ? FN_SUB : FN_ADD;
          1: fn = FN_SLL;
          2: fn = FN_SLT;
          3: fn = FN_SLTU;
          4: fn = FN_XOR;
          5: fn = (f7 == 32) ? FN_SRA : FN_SRL;
          6: fn = FN_OR;
          default: fn = FN_AND;
        endcase
        if (i[5] || f3 == 1 || f3 == 5)
          legal = (f7 == 0) || (f7 == 32 && (f3 == 5 || (f3 == 0 && i[5])));
      end
      7'h37: begin writes = 1'b1; r.num_b = imm_u; end
      7'h17: begin writes = 1'b1; r.num_a = pcv; r.num_b = imm_u; end
      7'h6f: begin writes = 1'b1; r.num_a = pcv; r.num_b = 32'd4; end
      7'h67: begin writes = 1'b1; r.num_a = pcv; r.num_b = 32'd4; legal = (f3 == 0); end
      7'h63: begin
        r.num_a = a;
        r.num_b = b;
        fn      = FN_SUB;
        brk     = br_map[f3];
        r.br    = 3'(brk);
        r.sgn   = (brk == 3 || brk == 4);
        legal   = (brk != 0);
      end
      7'h03: begin
        writes  = 1'b1;
        r.num_a = a;
        r.num_b = imm_i;
        legal   = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      end
      7'h23: begin r.num_a = a; r.num_b = imm_s; r.st = b; legal = (f3 <= 2); end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      r     = '0;
      r.ill = 1'b1;
      return r;
    end
    case (fn)
      FN_SUB:  r.op = 1'b1;
      FN_SLT:  begin r.f_cmp = 1'b1; r.op = 1'b1; r.sgn = 1'b1; end
      FN_SLTU: begin r.f_cmp = 1'b1; r.op = 1'b1; end
      FN_AND:  r.f_and = 1'b1;
      FN_OR:   r.f_or = 1'b1;
      FN_XOR:  r.f_xor = 1'b1;
      FN_SLL:  begin r.f_shift = 1'b1; r.lr = 1'b1; end
      FN_SRL:  r.f_shift = 1'b1;
      FN_SRA:  begin r.f_shift = 1'b1; r.al = 1'b1; end
      default: ;
    endcase
    if (writes) begin
      r.rd  = i[11:7];
      r.wen = (i[11:7] != 5'd0);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: model of the one-entry register, compared every falling edge.
  bit      have = 1'b0;
  bit      zero_chk = 1'b1;
  bundle_t cur = '0;

  always @(negedge clk) begin
    stim_t s;
    if (stim_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL stim_queue: got empty expected entry");
    end else begin
      s = stim_q.pop_front();
      if (zero_chk) begin
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_bundle", dut_b, '0);
        zero_chk = 1'b0;
      end
      chk("out_valid", out_valid, have);
      chk("in_ready", in_ready, (!have) || s.out_ready);
      if (have) chk("bundle", dut_b, cur);
      if (s.rst) begin
        have     = 1'b0;
        zero_chk = 1'b1;
      end else if (s.flush) begin
        have = 1'b0;
      end else if (s.in_valid && (!have || s.out_ready)) begin
        have = 1'b1;
        cur  = s.exp;
      end else if (s.out_ready) begin
        have = 1'b0;
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] r1,
                       input logic [31:0] r2, input bit ordy, input bit fl, input bit rs);
    stim_t       s;
    logic [31:0] pcv;
    pcv         = $urandom & 32'hFFFF_FFFC;
    in_valid    = v;
    inst        = ins;
    pc          = pcv;
    rs1_data    = r1;
    rs2_data    = r2;
    out_ready   = ordy;
    flush       = fl;
    rst         = rs;
    s.rst       = rs;
    s.flush     = fl;
    s.in_valid  = v;
    s.out_ready = ordy;
    s.exp       = ref_decode(ins, pcv, r1, r2);
    stim_q.push_back(s);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] opcs[9] = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23};
    int         k;
    logic [6:0] f7, opc;
    logic [4:0] rdv;
    k = $urandom_range(0, 9);
    if (k == 9) return $urandom;
    opc = opcs[k];
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    rdv = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom), rdv, opc};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk);
    #1;
    // addi, srai, slli with inst[25], bltu
    drive(1, 32'hFFD08293, 32'd10, 32'd0, 1, 0, 0);
    drive(1, 32'h40415193, 32'h8000_0000, 32'd7, 1, 0, 0);
    drive(1, 32'h02211193, 32'd5, 32'd6, 1, 0, 0);
    drive(1, 32'h0020E063, 32'd1, 32'd2, 1, 0, 0);
    drive(0, 32'h0, 32'd0, 32'd0, 1, 0, 0);
    // backpressure: held bundle, in_valid waiting
    drive(1, 32'h00B50533, 32'd3, 32'd4, 1, 0, 0);
    for (int k = 0; k < 3; k++) drive(1, 32'h40B50533, 32'd9, 32'd1, 0, 0, 0);
    drive(1, 32'h40B50533, 32'd9, 32'd1, 1, 0, 0);
    drive(0, 32'h0, 32'd0, 32'd0, 1, 0, 0);
    // flush while full with a new beat offered, then normal load
    drive(1, 32'h0000A0B7, 32'd0, 32'd0, 1, 0, 0);
    drive(1, 32'h00C12023, 32'd100, 32'hCAFE, 0, 1, 0);
    drive(1, 32'h00C12023, 32'd100, 32'hCAFE, 1, 0, 0);
    drive(0, 32'h0, 32'd0, 32'd0, 1, 0, 0);
    // reset mid-stall
    drive(1, 32'hFFD08293, 32'd10, 32'd0, 1, 0, 0);
    drive(1, 32'h0020E063, 32'd1, 32'd2, 0, 0, 0);
    drive(1, 32'h0020E063, 32'd1, 32'd2, 0, 0, 1);
    drive(0, 32'h0, 32'd0, 32'd0, 0, 0, 0);
    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 9) < 7, rand_inst(), $urandom,
            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
            $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
    end
    for (int k = 0; k < 3; k++) drive(0, 32'h0, 32'd0, 32'd0, 1, 0, 0);
    chk("drained", stim_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
